// File: rtl/avalon_octa_ram.sv
// 64-bit Avalon-MM responder on inferred RAM: programmable wait states, byte-lane writes,
// reads return READ_LATENCY cycles after accept, in order; waitrequest is the only backpressure.
module avalon_octa_ram #(
  parameter int ADDR_WIDTH   = 12,
  parameter int WAIT_STATES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [27:0] s_address,
  input  logic [7:0]  s_byteenable,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [63:0] s_writedata,
  output logic        s_waitrequest,
  output logic [63:0] s_readdata,
  output logic        s_readdatavalid
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  logic [63:0]                        r_mem [2**ADDR_WIDTH];
  logic [3:0]                         r_wcnt;
  logic [READ_LATENCY-1:0]            r_vld;
  logic [READ_LATENCY-1:0][63:0]      r_dat;

  logic                               w_cmd;
  logic                               w_accept;
  logic                               w_wr_acc;
  logic                               w_rd_acc;
  logic [ADDR_WIDTH-1:0]              w_idx;
  logic [READ_LATENCY:0]              w_vld_chain;
  logic [READ_LATENCY:0][63:0]        w_dat_chain;
  logic                               w_unused;

  assign w_cmd    = s_read | s_write;
  assign w_accept = w_cmd & (r_wcnt == LP_WAIT);
  // A simultaneous read+write is treated as a write only.
  assign w_wr_acc = w_accept & s_write;
  assign w_rd_acc = w_accept & s_read & ~s_write;
  assign w_idx    = s_address[ADDR_WIDTH+2:3];
  assign w_unused = ^{s_address[2:0], s_address[27:ADDR_WIDTH+3]};

  assign s_waitrequest = ~w_accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wcnt <= '0;
    end else if (!w_cmd || w_accept) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int i = 0; i < 8; i++) begin
        if (s_byteenable[i]) begin
          r_mem[w_idx][8*i +: 8] <= s_writedata[8*i +: 8];
        end
      end
    end
  end

  // Chain index 0 is the pipeline input; stage k is fed from chain index k.
  assign w_vld_chain = {r_vld, w_rd_acc};
  assign w_dat_chain = {r_dat, r_mem[w_idx]};

  // The last stage only loads on a valid beat so readdata holds between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_vld[k] <= w_vld_chain[k];
        if ((k < READ_LATENCY - 1) || w_vld_chain[k]) begin
          r_dat[k] <= w_dat_chain[k];
        end
      end
    end
  end

  assign s_readdatavalid = r_vld[READ_LATENCY-1];
  assign s_readdata      = r_dat[READ_LATENCY-1];

endmodule

// File: tb/tb_avalon_octa_ram.sv
// Directed bench for avalon_octa_ram: default-parameter instance plus a zero-wait, latency-3 instance.
module tb_avalon_octa_ram;

  localparam int A_WS = 1;
  localparam int A_RL = 2;
  localparam int P_WS = 0;
  localparam int P_RL = 3;

  typedef struct {
    int          cyc;
    logic [63:0] dat;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [27:0] a_address = '0;
  logic [7:0]  a_be = '0;
  logic        a_read = 1'b0;
  logic        a_write = 1'b0;
  logic [63:0] a_wdata = '0;
  logic        a_wait;
  logic [63:0] a_rdata;
  logic        a_rvld;

  logic [27:0] p_address = '0;
  logic [7:0]  p_be = '0;
  logic        p_read = 1'b0;
  logic        p_write = 1'b0;
  logic [63:0] p_wdata = '0;
  logic        p_wait;
  logic [63:0] p_rdata;
  logic        p_rvld;

  rd_t         a_q[$];
  rd_t         p_q[$];
  int          a_vld_cnt = 0;
  int          p_vld_cnt = 0;

  avalon_octa_ram #(.ADDR_WIDTH(12), .WAIT_STATES(A_WS), .READ_LATENCY(A_RL)) dut (
    .clk(clk), .reset_n(reset_n), .s_address(a_address), .s_byteenable(a_be),
    .s_read(a_read), .s_write(a_write), .s_writedata(a_wdata),
    .s_waitrequest(a_wait), .s_readdata(a_rdata), .s_readdatavalid(a_rvld)
  );

  avalon_octa_ram #(.ADDR_WIDTH(12), .WAIT_STATES(P_WS), .READ_LATENCY(P_RL)) dut_p (
    .clk(clk), .reset_n(reset_n), .s_address(p_address), .s_byteenable(p_be),
    .s_read(p_read), .s_write(p_write), .s_writedata(p_wdata),
    .s_waitrequest(p_wait), .s_readdata(p_rdata), .s_readdatavalid(p_rvld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    rd_t e;
    if (a_rvld === 1'b1) begin
      a_vld_cnt++;
      chk("a_rvld_expected", 64'(a_q.size() > 0), 64'd1);
      if (a_q.size() > 0) begin
        e = a_q.pop_front();
        chk("a_rd_cycle", 64'(cyc), 64'(e.cyc));
        chk("a_rd_data", a_rdata, e.dat);
      end
    end
    if (p_rvld === 1'b1) begin
      p_vld_cnt++;
      chk("p_rvld_expected", 64'(p_q.size() > 0), 64'd1);
      if (p_q.size() > 0) begin
        e = p_q.pop_front();
        chk("p_rd_cycle", 64'(cyc), 64'(e.cyc));
        chk("p_rd_data", p_rdata, e.dat);
      end
    end
  end

  // Holds a command on the default instance until accepted, checking the wait-state count.
  task automatic a_cmd(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [7:0] be, input logic [63:0] wd, input logic [63:0] exp_rd);
    int waits = 0;
    bit done = 0;
    @(posedge clk); #1;
    a_read = rd; a_write = wr; a_address = addr; a_be = be; a_wdata = wd;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (a_wait) waits++;
      else begin
        done = 1;
        if (rd && !wr) a_q.push_back('{cyc + A_RL, exp_rd});
      end
    end
    chk("a_accept_seen", 64'(done), 64'd1);
    chk("a_wait_states", 64'(waits), 64'(A_WS));
    @(posedge clk); #1;
    a_read = 1'b0; a_write = 1'b0;
  endtask

  initial begin
    logic [63:0] pdat [3];
    int v0;
    pdat[0] = 64'h1111111111111111;
    pdat[1] = 64'h2222222222222222;
    pdat[2] = 64'h3333333333333333;

    @(negedge clk);
    chk("rst_a_wait", 64'(a_wait), 64'd1);
    chk("rst_a_rvld", 64'(a_rvld), 64'd0);
    chk("rst_a_rdata", a_rdata, 64'd0);
    chk("rst_p_rvld", 64'(p_rvld), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Write then read, then byte-lane update.
    a_cmd(1'b0, 1'b1, 28'h40, 8'hFF, 64'h0123456789ABCDEF, '0);
    a_cmd(1'b1, 1'b0, 28'h40, 8'h00, '0, 64'h0123456789ABCDEF);
    a_cmd(1'b0, 1'b1, 28'h40, 8'h04, 64'h00000000005A0000, '0);
    a_cmd(1'b1, 1'b0, 28'h40, 8'h00, '0, 64'h01234567895ACDEF);

    // Aliased address with nonzero low bits lands on index 8.
    a_cmd(1'b0, 1'b1, 28'h8047, 8'hFF, 64'hDEADBEEFCAFEF00D, '0);
    a_cmd(1'b1, 1'b0, 28'h40, 8'h00, '0, 64'hDEADBEEFCAFEF00D);
    repeat (4) @(negedge clk);

    // Pipelined reads on the zero-wait, latency-3 instance.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      p_write = 1'b1; p_read = 1'b0; p_address = 28'(i * 8); p_be = 8'hFF; p_wdata = pdat[i];
      @(negedge clk);
      chk("p_wr_nowait", 64'(p_wait), 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      p_write = 1'b0; p_read = 1'b1; p_address = 28'(i * 8);
      @(negedge clk);
      chk("p_rd_nowait", 64'(p_wait), 64'd0);
      p_q.push_back('{cyc + P_RL, pdat[i]});
    end
    @(posedge clk); #1 p_read = 1'b0;
    repeat (6) @(negedge clk);
    chk("p_three_valids", 64'(p_vld_cnt), 64'd3);

    // Reset while a read is in flight.
    a_cmd(1'b1, 1'b0, 28'h40, 8'h00, '0, 64'hDEADBEEFCAFEF00D);
    reset_n = 1'b0;
    a_q.delete();
    p_q.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    v0 = a_vld_cnt;
    repeat (10) @(negedge clk);
    chk("rst_no_valid", 64'(a_vld_cnt - v0), 64'd0);
    chk("rst_rdata_zero", a_rdata, 64'd0);
    a_cmd(1'b1, 1'b0, 28'h40, 8'h00, '0, 64'hDEADBEEFCAFEF00D);
    repeat (4) @(negedge clk);

    // Simultaneous read and write behaves as a write only.
    v0 = a_vld_cnt;
    a_cmd(1'b1, 1'b1, 28'h80, 8'hFF, 64'h000000000000AAAA, '0);
    repeat (6) @(negedge clk);
    chk("rw_no_valid", 64'(a_vld_cnt - v0), 64'd0);
    a_cmd(1'b1, 1'b0, 28'h80, 8'h00, '0, 64'h000000000000AAAA);

    for (int k = 0; k < 20 && (a_q.size() + p_q.size()) != 0; k++) @(negedge clk);
    chk("a_queue_drained", 64'(a_q.size()), 64'd0);
    chk("p_queue_drained", 64'(p_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
